pcileech_rst_ctl: RTL and testbench



---
 rtl/pcileech_rst_pkg.sv | 19 +
 rtl/pcileech_sync_debounce.sv | 56 +++++
 rtl/pcileech_rst_ctl.sv | 178 +++++++++++++++++
 tb/tb_pcileech_rst_ctl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_rst_pkg.sv
// Shared types and helpers for the PCIe reset / power-management sequencer.
package pcileech_rst_pkg;

  localparam int unsigned STATE_W = 2;

  // Sequencer states; the encoding is visible on the debug port.
  typedef enum logic [STATE_W-1:0] {
    ST_POR     = 2'd0,
    ST_PERST   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } rst_state_e;

  // Counter width for a count of 'cycles': one spare bit above $clog2.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/pcileech_sync_debounce.sv
// 2-FF synchroniser followed by a stability filter: dout only follows the
// synchronised input after CYCLES consecutive cycles of disagreement.
// Everything resets to 0, i.e. an active-low input reads as asserted.
module pcileech_sync_debounce
  import pcileech_rst_pkg::*;
#(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din_async,
  output logic dout
);

  localparam int unsigned      CNT_W    = cnt_width(CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser shift and debounce count; any agreeing cycle restarts the count.
  always_comb begin
    sync1_d = din_async;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q >= CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/pcileech_rst_ctl.sv
// Reset and power-management sequencer for the PCIe board top level.
// Produces the system reset (COM/FIFO), the sequenced PCIe core reset,
// a debounced PERST# and a fixed-width WAKE# pulse.
// Optional build macro PCILEECH_RST_HEARTBEAT_EN: led_hb blinks from a
// free-running counter while in RUN; otherwise led_hb mirrors ~rst_pcie.
module pcileech_rst_ctl
  import pcileech_rst_pkg::*;
#(
  parameter int unsigned PARAM_POR_CYCLES      = 1000,
  parameter int unsigned PARAM_DEBOUNCE_CYCLES = 16,
  parameter int unsigned PARAM_RELEASE_CYCLES  = 1000,
  parameter int unsigned PARAM_WAKE_CYCLES     = 10000,
  parameter int unsigned PARAM_HB_BITS         = 26
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcie_perst_n,
  input  logic               wake_req,
  output logic               rst_sys,
  output logic               rst_pcie,
  output logic               perst_n_db,
  output logic               pcie_wake_n,
  output logic               wake_busy,
  output logic               led_hb,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned      POR_W     = cnt_width(PARAM_POR_CYCLES);
  localparam int unsigned      REL_W     = cnt_width(PARAM_RELEASE_CYCLES);
  localparam int unsigned      WAKE_W    = cnt_width(PARAM_WAKE_CYCLES);
  localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(PARAM_POR_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(PARAM_RELEASE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(PARAM_WAKE_CYCLES - 1);

  // Zero-length counts have no meaningful timing; refuse them at elaboration.
  if (PARAM_POR_CYCLES == 0 || PARAM_DEBOUNCE_CYCLES == 0 || PARAM_RELEASE_CYCLES == 0 ||
      PARAM_WAKE_CYCLES == 0 || PARAM_HB_BITS == 0) begin : g_bad_params
    $error("pcileech_rst_ctl: cycle counts and PARAM_HB_BITS must be non-zero");
  end

  rst_state_e        state_q, state_d;
  logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
  logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  logic              wake_busy_q, wake_busy_d;
  logic              wake_n_q, wake_n_d;
  logic              rst_sys_q, rst_sys_d;
  logic              rst_pcie_q, rst_pcie_d;
  logic              led_hb_q, led_hb_d;
  logic              perst_db;

  pcileech_sync_debounce #(
    .CYCLES (PARAM_DEBOUNCE_CYCLES)
  ) u_perst_db (
    .clk       (clk),
    .rst       (rst),
    .din_async (pcie_perst_n),
    .dout      (perst_db)
  );

  // Sequencer next state and its POR / RELEASE timers.
  always_comb begin
    state_d   = state_q;
    por_cnt_d = '0;
    rel_cnt_d = '0;
    unique case (state_q)
      ST_POR: begin
        if (por_cnt_q >= POR_LAST) begin
          state_d = perst_db ? ST_RELEASE : ST_PERST;
        end else begin
          por_cnt_d = por_cnt_q + POR_W'(1);
        end
      end
      ST_PERST: begin
        if (perst_db) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!perst_db) begin
          state_d = ST_PERST;
        end else if (rel_cnt_q >= REL_LAST) begin
          state_d = ST_RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_W'(1);
        end
      end
      ST_RUN: begin
        if (!perst_db) state_d = ST_PERST;
      end
      default: state_d = ST_POR;
    endcase
  end

  // WAKE# pulse: only started while settled in PERST, cut short if PERST is left.
  always_comb begin
    wake_busy_d = wake_busy_q;
    wake_cnt_d  = wake_cnt_q;
    if (state_d != ST_PERST) begin
      wake_busy_d = 1'b0;
      wake_cnt_d  = '0;
    end else if (wake_busy_q) begin
      if (wake_cnt_q >= WAKE_LAST) begin
        wake_busy_d = 1'b0;
        wake_cnt_d  = '0;
      end else begin
        wake_cnt_d = wake_cnt_q + WAKE_W'(1);
      end
    end else if (wake_req && state_q == ST_PERST) begin
      wake_busy_d = 1'b1;
      wake_cnt_d  = '0;
    end
    wake_n_d = ~wake_busy_d;
  end

  // Reset outputs follow the next state so they change on the transition edge.
  always_comb begin
    rst_sys_d  = (state_d == ST_POR);
    rst_pcie_d = (state_d != ST_RUN);
  end

`ifdef PCILEECH_RST_HEARTBEAT_EN
  logic [PARAM_HB_BITS-1:0] hb_cnt_q, hb_cnt_d;

  // Heartbeat: toggle on every counter wrap while in RUN, dark and cleared elsewhere.
  always_comb begin
    hb_cnt_d = '0;
    led_hb_d = 1'b0;
    if (state_d == ST_RUN) begin
      hb_cnt_d = hb_cnt_q + PARAM_HB_BITS'(1);
      led_hb_d = led_hb_q ^ (hb_cnt_q == '1);
    end
  end

  // Heartbeat counter register.
  always_ff @(posedge clk) begin
    if (rst) hb_cnt_q <= '0;
    else     hb_cnt_q <= hb_cnt_d;
  end
`else
  // Status LED lit whenever the PCIe core is out of reset.
  always_comb begin
    led_hb_d = ~rst_pcie_d;
  end
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_POR;
      por_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      wake_cnt_q  <= '0;
      wake_busy_q <= 1'b0;
      wake_n_q    <= 1'b1;
      rst_sys_q   <= 1'b1;
      rst_pcie_q  <= 1'b1;
      led_hb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      por_cnt_q   <= por_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      wake_busy_q <= wake_busy_d;
      wake_n_q    <= wake_n_d;
      rst_sys_q   <= rst_sys_d;
      rst_pcie_q  <= rst_pcie_d;
      led_hb_q    <= led_hb_d;
    end
  end

  assign rst_sys     = rst_sys_q;
  assign rst_pcie    = rst_pcie_q;
  assign perst_n_db  = perst_db;
  assign pcie_wake_n = wake_n_q;
  assign wake_busy   = wake_busy_q;
  assign led_hb      = led_hb_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pcileech_rst_ctl.sv
// Scoreboard bench for pcileech_rst_ctl with POR=8, DEBOUNCE=4, RELEASE=10, WAKE=6.
// Stimulus pushes {cycle, mask, expected outputs}; a negedge monitor compares.
module tb_pcileech_rst_ctl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pcie_perst_n;
  logic       wake_req;
  logic       rst_sys, rst_pcie, perst_n_db, pcie_wake_n, wake_busy, led_hb;
  logic [1:0] state;

`ifdef PCILEECH_RST_HEARTBEAT_EN
  localparam int LED_RUN = 0;
`else
  localparam int LED_RUN = 1;
`endif

  // Bit positions: {state[1:0], led, busy, wake_n, db, rst_pcie, rst_sys}
  localparam logic [7:0] M_SY   = 8'h01;
  localparam logic [7:0] M_PC   = 8'h02;
  localparam logic [7:0] M_DB   = 8'h04;
  localparam logic [7:0] M_WK   = 8'h08;
  localparam logic [7:0] M_BUSY = 8'h10;
  localparam logic [7:0] M_LED  = 8'h20;
  localparam logic [7:0] M_ST   = 8'hC0;
  localparam logic [7:0] M_ALL  = 8'hFF;

  typedef struct {
    int unsigned at;
    string       name;
    logic [7:0]  mask;
    logic [7:0]  val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  pcileech_rst_ctl #(
    .PARAM_POR_CYCLES      (8),
    .PARAM_DEBOUNCE_CYCLES (4),
    .PARAM_RELEASE_CYCLES  (10),
    .PARAM_WAKE_CYCLES     (6),
    .PARAM_HB_BITS         (26)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pcie_perst_n (pcie_perst_n),
    .wake_req     (wake_req),
    .rst_sys      (rst_sys),
    .rst_pcie     (rst_pcie),
    .perst_n_db   (perst_n_db),
    .pcie_wake_n  (pcie_wake_n),
    .wake_busy    (wake_busy),
    .led_hb       (led_hb),
    .state        (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pk(input int st, input int led, input int busy, input int wk,
                                    input int db, input int pc, input int sy);
    return {st[1:0], led[0], busy[0], wk[0], db[0], pc[0], sy[0]};
  endfunction

  // Expectation for the outputs after the off-th rising edge from now.
  task automatic exp_at(input int unsigned off, input string name, input logic [7:0] mask,
                        input logic [7:0] val);
    exp_t e;
    e.at   = cyc + off;
    e.name = name;
    e.mask = mask;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    act = {state, led_hb, wake_busy, pcie_wake_n, perst_n_db, rst_pcie, rst_sys};
    for (int i = int'(sb_q.size()) - 1; i >= 0; i--) begin
      if (sb_q[i].at == cyc) begin
        n_chk++;
        if ((act & sb_q[i].mask) !== (sb_q[i].val & sb_q[i].mask)) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", sb_q[i].name, cyc, act,
                   sb_q[i].val, sb_q[i].mask);
        end
        sb_q.delete(i);
      end else if (sb_q[i].at < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s missed at cyc=%0d (now %0d)", sb_q[i].name, sb_q[i].at, cyc);
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cyc=%0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pcie_perst_n = 1'b1;
    wake_req = 1'b0;
    step(3);

    // Power-on with PERST# high: POR 8 cycles, then RELEASE 10, then RUN.
    rst = 1'b0;
    exp_at(0,  "reset_values", M_ALL, pk(0, 0, 0, 1, 0, 1, 1));
    exp_at(5,  "por_db_low",   M_ST | M_SY | M_DB, pk(0, 0, 0, 1, 0, 1, 1));
    exp_at(6,  "por_db_up",    M_ST | M_SY | M_DB, pk(0, 0, 0, 1, 1, 1, 1));
    exp_at(7,  "por_last",     M_ST | M_SY | M_PC, pk(0, 0, 0, 1, 1, 1, 1));
    exp_at(8,  "por_end",      M_ST | M_SY | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(17, "rel_last",     M_ST | M_PC | M_LED, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(18, "run_entry",    M_ALL, pk(3, LED_RUN, 0, 1, 1, 0, 0));
    step(21);

    // 3-cycle glitch on PERST# in RUN must be filtered.
    pcie_perst_n = 1'b0;
    step(3);
    pcie_perst_n = 1'b1;
    exp_at(1, "glitch_a", M_ST | M_DB | M_PC, pk(3, 0, 0, 1, 1, 0, 0));
    exp_at(3, "glitch_b", M_ST | M_DB | M_PC, pk(3, 0, 0, 1, 1, 0, 0));
    exp_at(5, "glitch_c", M_ST | M_DB | M_PC, pk(3, 0, 0, 1, 1, 0, 0));
    exp_at(7, "glitch_d", M_ST | M_DB | M_PC, pk(3, 0, 0, 1, 1, 0, 0));
    step(10);

    // PERST# low for 20 cycles, with WAKE# requests while in PERST.
    pcie_perst_n = 1'b0;
    exp_at(6, "perst_db_fall", M_ST | M_DB | M_PC, pk(3, 0, 0, 1, 0, 0, 0));
    exp_at(7, "perst_entry",   M_ALL, pk(1, 0, 0, 1, 0, 1, 0));
    step(8);
    wake_req = 1'b1;
    exp_at(0, "wake_idle",  M_WK | M_BUSY, pk(0, 0, 0, 1, 0, 0, 0));
    exp_at(1, "wake_start", M_ST | M_WK | M_BUSY, pk(1, 0, 1, 0, 0, 0, 0));
    step(1);
    wake_req = 1'b0;
    step(2);
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    exp_at(2, "wake_hold",       M_WK | M_BUSY, pk(0, 0, 1, 0, 0, 0, 0));
    exp_at(3, "wake_end",        M_WK | M_BUSY, pk(0, 0, 0, 1, 0, 0, 0));
    exp_at(4, "wake_no_requeue", M_WK | M_BUSY | M_SY, pk(0, 0, 0, 1, 0, 0, 0));
    step(8);

    pcie_perst_n = 1'b1;
    exp_at(6, "rel_db_up", M_ST | M_DB | M_PC, pk(1, 0, 0, 1, 1, 1, 0));
    exp_at(7, "rel_entry", M_ST | M_PC | M_WK | M_BUSY | M_SY, pk(2, 0, 0, 1, 1, 1, 0));
    step(6);
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    exp_at(1,  "coincide_no_wake", M_ST | M_WK | M_BUSY, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(9,  "rel2_last",  M_ST | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(10, "run2_entry", M_ALL, pk(3, LED_RUN, 0, 1, 1, 0, 0));
    step(12);

    // WAKE# request in RUN is dropped.
    wake_req = 1'b1;
    exp_at(1, "run_wake_ign_a", M_ST | M_WK | M_BUSY, pk(3, 0, 0, 1, 0, 0, 0));
    exp_at(3, "run_wake_ign_b", M_ST | M_WK | M_BUSY, pk(3, 0, 0, 1, 0, 0, 0));
    step(1);
    wake_req = 1'b0;
    step(5);

    // PERST# re-asserted 5 cycles into RELEASE, then a fresh full release.
    pcie_perst_n = 1'b0;
    step(10);
    pcie_perst_n = 1'b1;
    exp_at(7, "rel3_entry", M_ST | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    step(5);
    pcie_perst_n = 1'b0;
    exp_at(4, "rel3_mid",     M_ST | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(6, "rel3_db_fall", M_ST | M_PC | M_DB, pk(2, 0, 0, 1, 0, 1, 0));
    exp_at(7, "rel3_abort",   M_ST | M_PC | M_SY, pk(1, 0, 0, 1, 0, 1, 0));
    step(15);
    pcie_perst_n = 1'b1;
    exp_at(7,  "rel4_entry", M_ST | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(16, "rel4_full",  M_ST | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(17, "run4_entry", M_ST | M_PC | M_SY, pk(3, 0, 0, 1, 1, 0, 0));
    step(20);

    // rst during an active WAKE# pulse.
    pcie_perst_n = 1'b0;
    step(8);
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    exp_at(0, "wake2_on", M_ST | M_WK | M_BUSY, pk(1, 0, 1, 0, 0, 0, 0));
    step(2);
    rst = 1'b1;
    exp_at(1, "rst_mid_wake", M_ALL, pk(0, 0, 0, 1, 0, 1, 1));
    step(2);
    rst = 1'b0;
    exp_at(7, "por2_last",    M_ST | M_SY, pk(0, 0, 0, 1, 0, 1, 1));
    exp_at(8, "por_to_perst", M_ST | M_SY | M_PC | M_DB, pk(1, 0, 0, 1, 0, 1, 0));
    step(10);

    // Pulse cut short by leaving PERST, then rst during RELEASE.
    pcie_perst_n = 1'b1;
    step(4);
    wake_req = 1'b1;
    step(1);
    wake_req = 1'b0;
    exp_at(0, "wake3_on",    M_ST | M_WK | M_BUSY, pk(1, 0, 1, 0, 0, 0, 0));
    exp_at(1, "wake3_hold",  M_ST | M_WK | M_BUSY | M_DB, pk(1, 0, 1, 0, 1, 0, 0));
    exp_at(2, "wake3_leave", M_ST | M_WK | M_BUSY, pk(2, 0, 0, 1, 0, 0, 0));
    step(3);
    rst = 1'b1;
    exp_at(1, "rst_mid_release", M_ALL, pk(0, 0, 0, 1, 0, 1, 1));
    step(2);
    rst = 1'b0;
    exp_at(5,  "por3_db_low", M_ST | M_DB | M_SY, pk(0, 0, 0, 1, 0, 1, 1));
    exp_at(6,  "por3_db_up",  M_ST | M_DB | M_SY, pk(0, 0, 0, 1, 1, 1, 1));
    exp_at(8,  "por3_end",    M_ST | M_SY | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(17, "rel5_last",   M_ST | M_PC, pk(2, 0, 0, 1, 1, 1, 0));
    exp_at(18, "run5_entry",  M_ALL, pk(3, LED_RUN, 0, 1, 1, 0, 0));
    step(20);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) step(1);
    while (sb_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s never compared (due cyc=%0d)", sb_q[0].name, sb_q[0].at);
      void'(sb_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
